// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU operation encoding and the ID/EX control bundle.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  // ALU_FUNCT tells EX to take the operation from the R-type funct field.
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_SLT   = 4'h4;
  localparam logic [3:0] ALU_FUNCT = 4'h8;

  typedef struct packed {
    logic       valid;
    logic       memToReg;
    logic       regWrite;
    logic       memWrite;
    logic       memRead;
    logic [3:0] aluOp;
    logic       aluSrc;
    logic       regDst;
  } id_ex_ctrl_t;

  function automatic id_ex_ctrl_t decode_ctrl(input logic [5:0] opcode);
    id_ex_ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin c.regWrite = 1'b1; c.regDst = 1'b1; c.aluOp = ALU_FUNCT; end
      OP_LW: begin
        c.memToReg = 1'b1; c.regWrite = 1'b1; c.memRead = 1'b1;
        c.aluSrc = 1'b1; c.aluOp = ALU_ADD;
      end
      OP_SW:   begin c.memWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALU_ADD; end
      OP_BEQ,
      OP_BNE:  c.aluOp = ALU_SUB;
      OP_J:    ;
      OP_ADDI: begin c.regWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALU_ADD; end
      OP_ANDI: begin c.regWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALU_AND; end
      OP_ORI:  begin c.regWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALU_OR;  end
      OP_SLTI: begin c.regWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALU_SLT; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/register_file_param.sv
// Two-read, one-write register file; entry 0 is hardwired to zero.
module register_file_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WRITE_FIRST    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] read_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0]     read_data_a,
  output logic [DATA_WIDTH-1:0]     read_data_b,
  input  logic                      write_en,
  input  logic [REG_ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data
);

  logic [DATA_WIDTH-1:0] regs [2**REG_ADDR_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_ADDR_WIDTH; i++) regs[i] <= '0;
    end else if (write_en && write_addr != '0) begin
      regs[write_addr] <= write_data;
    end
  end

  // Zero index wins over the bypass so a write to $0 never leaks through.
  always_comb begin
    read_data_a = '0;
    if (read_addr_a != '0) begin
      if (WRITE_FIRST != 0 && write_en && write_addr == read_addr_a) read_data_a = write_data;
      else read_data_a = regs[read_addr_a];
    end
  end

  always_comb begin
    read_data_b = '0;
    if (read_addr_b != '0) begin
      if (WRITE_FIRST != 0 && write_en && write_addr == read_addr_b) read_data_b = write_data;
      else read_data_b = regs[read_addr_b];
    end
  end

endmodule

// File: rtl/decode_stage_hazard.sv
// MIPS decode stage: register file, hazard detection, early branch resolution
// with MEM forwarding, and the ID/EX pipeline register.
module decode_stage_hazard
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int WRITE_FIRST     = 1,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ifIdValidInput,
  input  logic [31:0]                instructionInput,
  input  logic [DATA_WIDTH-1:0]      pc4Input,
  input  logic                       exRegWriteInput,
  input  logic                       exMemReadInput,
  input  logic [REG_ADDR_WIDTH-1:0]  exRdInput,
  input  logic                       memRegWriteInput,
  input  logic                       memMemReadInput,
  input  logic [REG_ADDR_WIDTH-1:0]  memRdInput,
  input  logic [DATA_WIDTH-1:0]      memAluResultInput,
  input  logic                       regWriteInput,
  input  logic [REG_ADDR_WIDTH-1:0]  writeRegisterInput,
  input  logic [DATA_WIDTH-1:0]      writeDataInput,
  output logic                       stallOutput,
  output logic                       ifFlushOutput,
  output logic                       pcRedirectOutput,
  output logic [DATA_WIDTH-1:0]      pcTargetOutput,
  output logic                       idExValidOutput,
  output logic                       memToRegOutput,
  output logic                       regWriteOutput,
  output logic                       memWriteOutput,
  output logic                       memReadOutput,
  output logic                       aluSrcOutput,
  output logic                       regDstOutput,
  output logic [3:0]                 aluOpOutput,
  output logic [DATA_WIDTH-1:0]      dataRsOutput,
  output logic [DATA_WIDTH-1:0]      dataRtOutput,
  output logic [DATA_WIDTH-1:0]      immediateExtendedOutput,
  output logic [REG_ADDR_WIDTH-1:0]  addressRsOutput,
  output logic [REG_ADDR_WIDTH-1:0]  addressRtOutput,
  output logic [REG_ADDR_WIDTH-1:0]  addressRdOutput,
  output logic [STALL_CNT_WIDTH-1:0] stallCountOutput
);

  logic [5:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
  logic [DATA_WIDTH-1:0]     imm_sext, imm_zext, imm_ext;
  logic [DATA_WIDTH-1:0]     rf_rs, rf_rt, br_rs, br_rt;
  logic [DATA_WIDTH-1:0]     branch_target, jump_target;
  logic                      is_rtype, is_sw, is_beq, is_bne, is_branch, is_jump, uses_rt;
  logic                      load_use, branch_stall, stall, taken;
  id_ex_ctrl_t               ctrl_d, ctrl_q;

  assign opcode   = instructionInput[31:26];
  assign rs       = REG_ADDR_WIDTH'(instructionInput[25:21]);
  assign rt       = REG_ADDR_WIDTH'(instructionInput[20:16]);
  assign rd       = REG_ADDR_WIDTH'(instructionInput[15:11]);
  assign imm_sext = {{(DATA_WIDTH-16){instructionInput[15]}}, instructionInput[15:0]};
  assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, instructionInput[15:0]};

  assign is_rtype  = opcode == OP_RTYPE;
  assign is_sw     = opcode == OP_SW;
  assign is_beq    = opcode == OP_BEQ;
  assign is_bne    = opcode == OP_BNE;
  assign is_jump   = opcode == OP_J;
  assign is_branch = is_beq || is_bne;
  assign uses_rt   = is_rtype || is_sw || is_branch;
  // Logical immediates are zero-extended so masks keep their upper bits clear.
  assign imm_ext   = (opcode == OP_ANDI || opcode == OP_ORI) ? imm_zext : imm_sext;

  register_file_param #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .WRITE_FIRST   (WRITE_FIRST)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .read_addr_a(rs),
    .read_addr_b(rt),
    .read_data_a(rf_rs),
    .read_data_b(rf_rt),
    .write_en   (regWriteInput),
    .write_addr (writeRegisterInput),
    .write_data (writeDataInput)
  );

  assign load_use = ifIdValidInput && exMemReadInput && exRdInput != '0 &&
                    (exRdInput == rs || (uses_rt && exRdInput == rt));

  assign branch_stall = ifIdValidInput && is_branch &&
                        ((exRegWriteInput && (exRdInput == rs || exRdInput == rt)) ||
                         (memMemReadInput && (memRdInput == rs || memRdInput == rt)));

  assign stall = load_use || branch_stall;

  // A MEM-stage ALU result is already final; a MEM-stage load is not, hence the stall above.
  always_comb begin
    br_rs = rf_rs;
    br_rt = rf_rt;
    if (memRegWriteInput && !memMemReadInput && memRdInput != '0) begin
      if (memRdInput == rs) br_rs = memAluResultInput;
      if (memRdInput == rt) br_rt = memAluResultInput;
    end
  end

  assign taken = (is_beq && br_rs == br_rt) || (is_bne && br_rs != br_rt);

  assign branch_target = pc4Input + (imm_sext << 2);

  always_comb begin
    jump_target       = pc4Input;
    jump_target[27:0] = {instructionInput[25:0], 2'b00};
  end

  assign pcTargetOutput   = is_jump ? jump_target : branch_target;
  assign pcRedirectOutput = ifIdValidInput && !stall && (is_jump || taken);
  assign ifFlushOutput    = pcRedirectOutput;
  assign stallOutput      = stall;

  always_comb begin
    ctrl_d       = decode_ctrl(opcode);
    ctrl_d.valid = 1'b1;
  end

  // Bubbles clear only the control bundle; operand fields keep their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q                  <= '0;
      dataRsOutput            <= '0;
      dataRtOutput            <= '0;
      immediateExtendedOutput <= '0;
      addressRsOutput         <= '0;
      addressRtOutput         <= '0;
      addressRdOutput         <= '0;
    end else if (stall || !ifIdValidInput) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q                  <= ctrl_d;
      dataRsOutput            <= rf_rs;
      dataRtOutput            <= rf_rt;
      immediateExtendedOutput <= imm_ext;
      addressRsOutput         <= rs;
      addressRtOutput         <= rt;
      addressRdOutput         <= rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stallCountOutput <= '0;
    else if (stall && stallCountOutput != '1) stallCountOutput <= stallCountOutput + 1'b1;
  end

  assign idExValidOutput = ctrl_q.valid;
  assign memToRegOutput  = ctrl_q.memToReg;
  assign regWriteOutput  = ctrl_q.regWrite;
  assign memWriteOutput  = ctrl_q.memWrite;
  assign memReadOutput   = ctrl_q.memRead;
  assign aluOpOutput     = ctrl_q.aluOp;
  assign aluSrcOutput    = ctrl_q.aluSrc;
  assign regDstOutput    = ctrl_q.regDst;

endmodule

// File: tb/tb_decode_stage_hazard.sv
// Directed bench for decode_stage_hazard; a second instance with WRITE_FIRST=0 checks read-after-write ordering.
module tb_decode_stage_hazard;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifIdValidInput;
  logic [31:0] instructionInput, pc4Input;
  logic        exRegWriteInput, exMemReadInput;
  logic [4:0]  exRdInput;
  logic        memRegWriteInput, memMemReadInput;
  logic [4:0]  memRdInput;
  logic [31:0] memAluResultInput;
  logic        regWriteInput;
  logic [4:0]  writeRegisterInput;
  logic [31:0] writeDataInput;

  logic        stallOutput, ifFlushOutput, pcRedirectOutput, idExValidOutput;
  logic [31:0] pcTargetOutput;
  logic        memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput, aluSrcOutput, regDstOutput;
  logic [3:0]  aluOpOutput;
  logic [31:0] dataRsOutput, dataRtOutput, immediateExtendedOutput;
  logic [4:0]  addressRsOutput, addressRtOutput, addressRdOutput;
  logic [15:0] stallCountOutput;

  logic        w0_stall, w0_flush, w0_redirect, w0_valid;
  logic [31:0] w0_target;
  logic        w0_m2r, w0_rw, w0_mw, w0_mr, w0_asrc, w0_rdst;
  logic [3:0]  w0_aluop;
  logic [31:0] w0_rs_data, w0_rt_data, w0_imm;
  logic [4:0]  w0_rs_addr, w0_rt_addr, w0_rd_addr;
  logic [15:0] w0_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage_hazard #(.WRITE_FIRST(1)) dut (
    .clk(clk), .reset(reset), .ifIdValidInput(ifIdValidInput),
    .instructionInput(instructionInput), .pc4Input(pc4Input),
    .exRegWriteInput(exRegWriteInput), .exMemReadInput(exMemReadInput), .exRdInput(exRdInput),
    .memRegWriteInput(memRegWriteInput), .memMemReadInput(memMemReadInput),
    .memRdInput(memRdInput), .memAluResultInput(memAluResultInput),
    .regWriteInput(regWriteInput), .writeRegisterInput(writeRegisterInput),
    .writeDataInput(writeDataInput),
    .stallOutput(stallOutput), .ifFlushOutput(ifFlushOutput),
    .pcRedirectOutput(pcRedirectOutput), .pcTargetOutput(pcTargetOutput),
    .idExValidOutput(idExValidOutput), .memToRegOutput(memToRegOutput),
    .regWriteOutput(regWriteOutput), .memWriteOutput(memWriteOutput),
    .memReadOutput(memReadOutput), .aluSrcOutput(aluSrcOutput), .regDstOutput(regDstOutput),
    .aluOpOutput(aluOpOutput), .dataRsOutput(dataRsOutput), .dataRtOutput(dataRtOutput),
    .immediateExtendedOutput(immediateExtendedOutput),
    .addressRsOutput(addressRsOutput), .addressRtOutput(addressRtOutput),
    .addressRdOutput(addressRdOutput), .stallCountOutput(stallCountOutput)
  );

  decode_stage_hazard #(.WRITE_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .ifIdValidInput(ifIdValidInput),
    .instructionInput(instructionInput), .pc4Input(pc4Input),
    .exRegWriteInput(exRegWriteInput), .exMemReadInput(exMemReadInput), .exRdInput(exRdInput),
    .memRegWriteInput(memRegWriteInput), .memMemReadInput(memMemReadInput),
    .memRdInput(memRdInput), .memAluResultInput(memAluResultInput),
    .regWriteInput(regWriteInput), .writeRegisterInput(writeRegisterInput),
    .writeDataInput(writeDataInput),
    .stallOutput(w0_stall), .ifFlushOutput(w0_flush),
    .pcRedirectOutput(w0_redirect), .pcTargetOutput(w0_target),
    .idExValidOutput(w0_valid), .memToRegOutput(w0_m2r),
    .regWriteOutput(w0_rw), .memWriteOutput(w0_mw),
    .memReadOutput(w0_mr), .aluSrcOutput(w0_asrc), .regDstOutput(w0_rdst),
    .aluOpOutput(w0_aluop), .dataRsOutput(w0_rs_data), .dataRtOutput(w0_rt_data),
    .immediateExtendedOutput(w0_imm),
    .addressRsOutput(w0_rs_addr), .addressRtOutput(w0_rt_addr),
    .addressRdOutput(w0_rd_addr), .stallCountOutput(w0_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifIdValidInput = 0; instructionInput = 0; pc4Input = 0;
    exRegWriteInput = 0; exMemReadInput = 0; exRdInput = 0;
    memRegWriteInput = 0; memMemReadInput = 0; memRdInput = 0; memAluResultInput = 0;
    regWriteInput = 0; writeRegisterInput = 0; writeDataInput = 0;
  endtask

  task automatic rf_write(input logic [4:0] addr, input logic [31:0] data);
    clear_inputs();
    regWriteInput = 1; writeRegisterInput = addr; writeDataInput = data;
    tick();
    regWriteInput = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #1;
    total++; if (idExValidOutput !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", idExValidOutput); end
    total++; if (regWriteOutput !== 1'b0) begin bad++; $display("FAIL rst_regwrite got=%0h exp=0", regWriteOutput); end
    total++; if (dataRsOutput !== 32'h0) begin bad++; $display("FAIL rst_data_rs got=%0h exp=0", dataRsOutput); end
    total++; if (stallCountOutput !== 16'h0) begin bad++; $display("FAIL rst_count got=%0h exp=0", stallCountOutput); end
    #2 reset = 0;
  endtask

  // lw $2,0($1) in EX, add $3,$2,$4 in ID
  task automatic test_load_use();
    clear_inputs();
    ifIdValidInput = 1; instructionInput = 32'h00441820;
    exMemReadInput = 1; exRegWriteInput = 1; exRdInput = 2;
    #1;
    total++; if (stallOutput !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0h exp=1", stallOutput); end
    total++; if (ifFlushOutput !== 1'b0) begin bad++; $display("FAIL lu_flush got=%0h exp=0", ifFlushOutput); end
    tick();
    total++; if (idExValidOutput !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h exp=0", idExValidOutput); end
    total++; if (stallCountOutput !== 16'd1) begin bad++; $display("FAIL lu_count got=%0d exp=1", stallCountOutput); end
    exMemReadInput = 0; exRegWriteInput = 0; exRdInput = 0;
    memMemReadInput = 1; memRegWriteInput = 1; memRdInput = 2;
    #1;
    total++; if (stallOutput !== 1'b0) begin bad++; $display("FAIL lu_release got=%0h exp=0", stallOutput); end
    tick();
    total++; if (idExValidOutput !== 1'b1) begin bad++; $display("FAIL lu_issue got=%0h exp=1", idExValidOutput); end
    total++; if (regDstOutput !== 1'b1) begin bad++; $display("FAIL lu_regdst got=%0h exp=1", regDstOutput); end
    total++; if (addressRdOutput !== 5'd3) begin bad++; $display("FAIL lu_rd got=%0d exp=3", addressRdOutput); end
    total++; if (aluOpOutput !== 4'h8) begin bad++; $display("FAIL lu_aluop got=%0h exp=8", aluOpOutput); end
    total++; if (stallCountOutput !== 16'd1) begin bad++; $display("FAIL lu_count2 got=%0d exp=1", stallCountOutput); end
  endtask

  // beq $1,$2,+3 at pc4=0x100 with $1=$2=5
  task automatic test_beq();
    rf_write(1, 32'd5);
    rf_write(2, 32'd5);
    clear_inputs();
    ifIdValidInput = 1; instructionInput = 32'h10220003; pc4Input = 32'h100;
    #1;
    total++; if (pcRedirectOutput !== 1'b1) begin bad++; $display("FAIL beq_redirect got=%0h exp=1", pcRedirectOutput); end
    total++; if (ifFlushOutput !== 1'b1) begin bad++; $display("FAIL beq_flush got=%0h exp=1", ifFlushOutput); end
    total++; if (pcTargetOutput !== 32'h10C) begin bad++; $display("FAIL beq_target got=%0h exp=10c", pcTargetOutput); end
    total++; if (stallOutput !== 1'b0) begin bad++; $display("FAIL beq_stall got=%0h exp=0", stallOutput); end
    tick();
    total++; if (idExValidOutput !== 1'b1) begin bad++; $display("FAIL beq_valid got=%0h exp=1", idExValidOutput); end
    total++; if (regWriteOutput !== 1'b0) begin bad++; $display("FAIL beq_regwrite got=%0h exp=0", regWriteOutput); end
    total++; if (aluOpOutput !== 4'h1) begin bad++; $display("FAIL beq_aluop got=%0h exp=1", aluOpOutput); end
    total++; if (dataRsOutput !== 32'd5) begin bad++; $display("FAIL beq_data_rs got=%0h exp=5", dataRsOutput); end
    total++; if (immediateExtendedOutput !== 32'd3) begin bad++; $display("FAIL beq_imm got=%0h exp=3", immediateExtendedOutput); end
    instructionInput = 32'h14220003;
    #1;
    total++; if (pcRedirectOutput !== 1'b0) begin bad++; $display("FAIL bne_equal_redirect got=%0h exp=0", pcRedirectOutput); end
  endtask

  // bne $1,$2 with $1 forwarded as 7 from MEM
  task automatic test_bne_forward();
    clear_inputs();
    ifIdValidInput = 1; instructionInput = 32'h14220003; pc4Input = 32'h100;
    memRdInput = 1; memRegWriteInput = 1; memAluResultInput = 32'd7;
    #1;
    total++; if (pcRedirectOutput !== 1'b1) begin bad++; $display("FAIL fwd_redirect got=%0h exp=1", pcRedirectOutput); end
    total++; if (pcTargetOutput !== 32'h10C) begin bad++; $display("FAIL fwd_target got=%0h exp=10c", pcTargetOutput); end
    total++; if (stallOutput !== 1'b0) begin bad++; $display("FAIL fwd_stall got=%0h exp=0", stallOutput); end
    memMemReadInput = 1;
    #1;
    total++; if (stallOutput !== 1'b1) begin bad++; $display("FAIL fwd_memload_stall got=%0h exp=1", stallOutput); end
    total++; if (pcRedirectOutput !== 1'b0) begin bad++; $display("FAIL fwd_memload_redirect got=%0h exp=0", pcRedirectOutput); end
    clear_inputs();
  endtask

  // lw $5 in EX, beq $5,$0,+2 at pc4=0x200; loaded value 0 arrives via WB
  task automatic test_branch_on_load();
    rf_write(5, 32'd3);
    clear_inputs();
    ifIdValidInput = 1; instructionInput = 32'h10A00002; pc4Input = 32'h200;
    exMemReadInput = 1; exRegWriteInput = 1; exRdInput = 5;
    #1;
    total++; if (stallOutput !== 1'b1) begin bad++; $display("FAIL bl_stall_ex got=%0h exp=1", stallOutput); end
    tick();
    exMemReadInput = 0; exRegWriteInput = 0; exRdInput = 0;
    memMemReadInput = 1; memRegWriteInput = 1; memRdInput = 5;
    #1;
    total++; if (stallOutput !== 1'b1) begin bad++; $display("FAIL bl_stall_mem got=%0h exp=1", stallOutput); end
    total++; if (pcRedirectOutput !== 1'b0) begin bad++; $display("FAIL bl_redirect_mem got=%0h exp=0", pcRedirectOutput); end
    tick();
    memMemReadInput = 0; memRegWriteInput = 0; memRdInput = 0;
    regWriteInput = 1; writeRegisterInput = 5; writeDataInput = 32'd0;
    #1;
    total++; if (stallOutput !== 1'b0) begin bad++; $display("FAIL bl_stall_wb got=%0h exp=0", stallOutput); end
    total++; if (pcRedirectOutput !== 1'b1) begin bad++; $display("FAIL bl_redirect got=%0h exp=1", pcRedirectOutput); end
    total++; if (pcTargetOutput !== 32'h208) begin bad++; $display("FAIL bl_target got=%0h exp=208", pcTargetOutput); end
    tick();
    total++; if (stallCountOutput !== 16'd3) begin bad++; $display("FAIL bl_count got=%0d exp=3", stallCountOutput); end
    total++; if (idExValidOutput !== 1'b1) begin bad++; $display("FAIL bl_valid got=%0h exp=1", idExValidOutput); end
    clear_inputs();
  endtask

  task automatic test_jump();
    clear_inputs();
    ifIdValidInput = 1; instructionInput = 32'h08000040; pc4Input = 32'h30000004;
    #1;
    total++; if (pcTargetOutput !== 32'h30000100) begin bad++; $display("FAIL j_target got=%0h exp=30000100", pcTargetOutput); end
    total++; if (pcRedirectOutput !== 1'b1) begin bad++; $display("FAIL j_redirect got=%0h exp=1", pcRedirectOutput); end
    total++; if (stallOutput !== 1'b0) begin bad++; $display("FAIL j_stall got=%0h exp=0", stallOutput); end
    tick();
    total++; if (regWriteOutput !== 1'b0) begin bad++; $display("FAIL j_regwrite got=%0h exp=0", regWriteOutput); end
    total++; if (memReadOutput !== 1'b0) begin bad++; $display("FAIL j_memread got=%0h exp=0", memReadOutput); end
    // rs field of this jump is $1, colliding with a load in EX: stall wins
    instructionInput = 32'h08220040;
    exMemReadInput = 1; exRegWriteInput = 1; exRdInput = 1;
    #1;
    total++; if (stallOutput !== 1'b1) begin bad++; $display("FAIL jlu_stall got=%0h exp=1", stallOutput); end
    total++; if (pcRedirectOutput !== 1'b0) begin bad++; $display("FAIL jlu_redirect got=%0h exp=0", pcRedirectOutput); end
    total++; if (ifFlushOutput !== 1'b0) begin bad++; $display("FAIL jlu_flush got=%0h exp=0", ifFlushOutput); end
    tick();
    total++; if (idExValidOutput !== 1'b0) begin bad++; $display("FAIL jlu_bubble got=%0h exp=0", idExValidOutput); end
    total++; if (stallCountOutput !== 16'd4) begin bad++; $display("FAIL jlu_count got=%0d exp=4", stallCountOutput); end
    ifIdValidInput = 0;
    #1;
    total++; if (stallOutput !== 1'b0) begin bad++; $display("FAIL gate_stall got=%0h exp=0", stallOutput); end
    total++; if (pcRedirectOutput !== 1'b0) begin bad++; $display("FAIL gate_redirect got=%0h exp=0", pcRedirectOutput); end
    clear_inputs();
  endtask

  task automatic test_regfile();
    rf_write(7, 32'h1111);
    clear_inputs();
    ifIdValidInput = 1; instructionInput = 32'h00E04020;
    regWriteInput = 1; writeRegisterInput = 7; writeDataInput = 32'hDEAD;
    tick();
    total++; if (dataRsOutput !== 32'hDEAD) begin bad++; $display("FAIL wf1_bypass got=%0h exp=dead", dataRsOutput); end
    total++; if (w0_rs_data !== 32'h1111) begin bad++; $display("FAIL wf0_old got=%0h exp=1111", w0_rs_data); end
    regWriteInput = 0;
    tick();
    total++; if (dataRsOutput !== 32'hDEAD) begin bad++; $display("FAIL wf1_next got=%0h exp=dead", dataRsOutput); end
    total++; if (w0_rs_data !== 32'hDEAD) begin bad++; $display("FAIL wf0_next got=%0h exp=dead", w0_rs_data); end
    instructionInput = 32'h00074020;
    regWriteInput = 1; writeRegisterInput = 0; writeDataInput = 32'hFFFF;
    tick();
    total++; if (dataRsOutput !== 32'h0) begin bad++; $display("FAIL r0_bypass got=%0h exp=0", dataRsOutput); end
    total++; if (dataRtOutput !== 32'hDEAD) begin bad++; $display("FAIL r0_rt got=%0h exp=dead", dataRtOutput); end
    regWriteInput = 0;
    tick();
    total++; if (dataRsOutput !== 32'h0) begin bad++; $display("FAIL r0_hold got=%0h exp=0", dataRsOutput); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    ifIdValidInput = 1; instructionInput = 32'h00441820;
    exMemReadInput = 1; exRegWriteInput = 1; exRdInput = 2;
    tick();
    total++; if (stallCountOutput !== 16'd5) begin bad++; $display("FAIL ms_count got=%0d exp=5", stallCountOutput); end
    #2 reset = 1;
    #1;
    total++; if (stallCountOutput !== 16'd0) begin bad++; $display("FAIL ms_count_clr got=%0d exp=0", stallCountOutput); end
    total++; if (idExValidOutput !== 1'b0) begin bad++; $display("FAIL ms_valid got=%0h exp=0", idExValidOutput); end
    total++; if (dataRsOutput !== 32'h0) begin bad++; $display("FAIL ms_data got=%0h exp=0", dataRsOutput); end
    total++; if (addressRdOutput !== 5'd0) begin bad++; $display("FAIL ms_rd got=%0d exp=0", addressRdOutput); end
    clear_inputs();
    #1 reset = 0;
    ifIdValidInput = 1; instructionInput = 32'h00E04020;
    #1;
    total++; if (stallOutput !== 1'b0) begin bad++; $display("FAIL post_stall got=%0h exp=0", stallOutput); end
    tick();
    total++; if (idExValidOutput !== 1'b1) begin bad++; $display("FAIL post_valid got=%0h exp=1", idExValidOutput); end
    total++; if (dataRsOutput !== 32'h0) begin bad++; $display("FAIL post_rf_clear got=%0h exp=0", dataRsOutput); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_beq();
    test_bne_forward();
    test_branch_on_load();
    test_jump();
    test_regfile();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_hazard.md
# decode_stage_hazard

Parametrised MIPS instruction-decode stage with registered ID/EX output, integrated register file, load-use and branch hazard detection, and early branch resolution with MEM-stage forwarding. Sits between the IF/ID and EX stages. It replaces the purely combinational decode by owning the ID/EX pipeline register and generating stall, bubble and flush controls for IF. It adds BNE support and a saturating stall counter.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and register width
- REG_ADDR_WIDTH, 5, register index width; register file holds 2^REG_ADDR_WIDTH entries
- WRITE_FIRST, 1, 1 = a same-cycle WB write is bypassed to the read ports
- STALL_CNT_WIDTH, 16, width of the stall counter

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high
- ifIdValidInput  in  1  IF/ID holds a real instruction
- instructionInput  in  32  IF/ID instruction
- pc4Input  in  DATA_WIDTH  IF/ID PC+4
- exRegWriteInput, exMemReadInput  in  1  control bits of the instruction now in EX
- exRdInput  in  REG_ADDR_WIDTH  destination register in EX
- memRegWriteInput, memMemReadInput  in  1  control bits of the instruction now in MEM
- memRdInput  in  REG_ADDR_WIDTH  destination register in MEM
- memAluResultInput  in  DATA_WIDTH  ALU result in MEM
- regWriteInput  in  1  WB write enable
- writeRegisterInput  in  REG_ADDR_WIDTH  WB write index
- writeDataInput  in  DATA_WIDTH  WB write data
- stallOutput  out  1  IF must hold PC and IF/ID
- ifFlushOutput  out  1  IF must squash IF/ID
- pcRedirectOutput  out  1  IF must load pcTargetOutput
- pcTargetOutput  out  DATA_WIDTH  branch or jump target
- idExValidOutput  out  1  registered; ID/EX holds a real instruction
- memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput, aluSrcOutput, regDstOutput  out  1  registered controls
- aluOpOutput  out  4  registered ALU operation
- dataRsOutput, dataRtOutput, immediateExtendedOutput  out  DATA_WIDTH  registered operands
- addressRsOutput, addressRtOutput, addressRdOutput  out  REG_ADDR_WIDTH  registered indices
- stallCountOutput  out  STALL_CNT_WIDTH  saturating count of stall cycles

## Operation
- Opcodes decoded: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A.
- Any other opcode decodes to a NOP (all controls 0).
- usesRt = R-type, sw, beq, bne.
- Register 0 reads as 0 and ignores writes. With WRITE_FIRST=1, a read whose index matches writeRegisterInput while regWriteInput=1 returns writeDataInput.
- Load-use stall: exMemRead && exRd≠0 && (exRd==rs || (usesRt && exRd==rt)).
- Branch stall, applied only to beq/bne:
  - a source register matches an EX destination with exRegWrite;
  - or a source register matches a MEM destination with memMemRead.
- Branch forwarding: a source register matching memRd with memRegWrite && !memMemRead && memRd≠0 takes memAluResultInput. Otherwise the source comes from the register file.
- Taken condition: beq takes when operands are equal; bne takes when they are not equal.
- Branch target = pc4 + (signext(imm16) << 2).
- Jump target = {pc4[31:28], instr[25:0], 2'b00}.
- Stall and redirect are gated by ifIdValidInput.
- stallOutput = load-use stall || branch stall.
- pcRedirectOutput = !stall && (jump || taken branch); ifFlushOutput equals pcRedirectOutput.
- ID/EX register update at each posedge:
  - on stall or !ifIdValidInput: load a bubble (valid=0, all controls 0, data fields hold);
  - otherwise: load the decoded bundle with valid=1.
- Branch and jump instructions enter ID/EX with regWrite=memWrite=memRead=0.
- stallCountOutput increments on each cycle with stallOutput=1 and saturates at all-ones.

## Timing
- Reset, asynchronous and immediate:
  - all ID/EX outputs are 0;
  - stallCountOutput is 0;
  - all register-file entries are 0.
- stallOutput, ifFlushOutput, pcRedirectOutput and pcTargetOutput are combinational in the same cycle as the instruction is in ID.
- ID/EX outputs appear one cycle after ID.
- Load-use costs exactly 1 stall cycle.
- Branch stall cycles:
  - branch on an ALU producer in EX: 1 cycle;
  - branch on a load in EX: 2 cycles (EX, then MEM).
- Simultaneous load-use and redirect: the stall wins; no redirect that cycle.
- A WB write at edge N is visible to a read in cycle N+1 regardless of WRITE_FIRST.
- Reset asserted mid-stall clears the counter and the bubble state. The first valid instruction after reset proceeds with no stall unless the hazard inputs indicate one.

## Structure
- Package decode_pkg holds:
  - the opcode localparams;
  - the aluOp encoding (4-bit);
  - a packed struct id_ex_ctrl_t {valid, memToReg, regWrite, memWrite, memRead, aluOp, aluSrc, regDst}.
- One sub-module, register_file_param, parametrised by DATA_WIDTH, REG_ADDR_WIDTH and WRITE_FIRST. It has 2 read ports, 1 write port and asynchronous reset.

## Test plan
- lw $2,0($1) in EX, add $3,$2,$4 in ID -> stallOutput=1 for 1 cycle; idExValidOutput=0 next cycle; then add issues; stallCountOutput=1.
- $1=5 and $2=5 in the register file, beq $1,$2,+3 at pc4=0x100 -> pcRedirectOutput=1, pcTargetOutput=0x10C, ifFlushOutput=1.
- bne $1,$2 with memRd=1, memRegWrite=1, memAluResultInput=7, RF $1=5, RF $2=5 -> forwarded 7≠5, so taken.
- lw $5 in EX, then beq $5,$0 in ID -> 2 stall cycles, then the branch resolves.
- j 0x0000040 at pc4=0x30000004 -> pcTargetOutput=0x30000100, no stall.
- Write $7=0xDEAD during a read of $7 -> 0xDEAD when WRITE_FIRST=1, old value when 0; a write to $0 is ignored. Assert reset mid-stall -> all outputs 0 immediately.
